// File: rtl/ddr3_pkg.sv
// Shared command codes, FSM states and grant-side type for the DDR3 read/write arbiter.
package ddr3_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    IDLE,
    WR_ISSUE,
    RD_ISSUE
  } arb_state_t;

  typedef enum logic {
    SIDE_WRITE,
    SIDE_READ
  } arb_side_t;

  function automatic arb_side_t other_side(input arb_side_t s);
    return (s == SIDE_WRITE) ? SIDE_READ : SIDE_WRITE;
  endfunction

endpackage

// File: rtl/ddr3_rw_arbiter_if.sv
// DDR3 controller user-port (app_*) bundle; master is the arbiter, slave is the controller.
interface ddr3_rw_arbiter_if #(
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 64,
  parameter int APP_MASK_WIDTH = 8
);
  logic                      app_rdy;
  logic                      app_wdf_rdy;
  logic                      app_rd_data_valid;
  logic [APP_DATA_WIDTH-1:0] app_rd_data;
  logic                      app_en;
  logic [2:0]                app_cmd;
  logic [ADDR_WIDTH-1:0]     app_addr;
  logic [APP_DATA_WIDTH-1:0] app_wdf_data;
  logic                      app_wdf_wren;
  logic                      app_wdf_end;
  logic [APP_MASK_WIDTH-1:0] app_wdf_mask;
  logic                      app_burst;

  modport master (
    input  app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
    output app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end,
           app_wdf_mask, app_burst
  );

  modport slave (
    output app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
    input  app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end,
           app_wdf_mask, app_burst
  );
endinterface

// File: rtl/ddr3_rd_credit.sv
// Tracks read commands in flight, gates new reads at the limit, flags unexpected read beats.
module ddr3_rd_credit #(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 rd_accept,
  input  logic                                 rd_beat,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] rd_outstanding,
  output logic                                 rd_avail,
  output logic                                 rd_underflow
);
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

  assign rd_avail = (rd_outstanding < CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_outstanding <= '0;
      rd_underflow   <= 1'b0;
    end else if (rd_accept && !rd_beat) begin
      if (rd_outstanding != CNT_MAX) rd_outstanding <= rd_outstanding + CNT_WIDTH'(1);
    end else if (rd_beat && !rd_accept) begin
      if (rd_outstanding == '0) rd_underflow <= 1'b1;
      else                      rd_outstanding <= rd_outstanding - CNT_WIDTH'(1);
    end
  end
endmodule

// File: rtl/ddr3_rw_arbiter.sv
// Shares one DDR3 app_* port between a write and a read requester with bounded-run round-robin.
module ddr3_rw_arbiter
  import ddr3_pkg::*;
#(
  parameter int ADDR_WIDTH      = 28,
  parameter int APP_DATA_WIDTH  = 64,
  parameter int APP_MASK_WIDTH  = 8,
  parameter int USER_ADDR_WIDTH = 16,
  parameter int USER_DATA_WIDTH = 48,
  parameter int MAX_RUN         = 8,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 init_calib_complete,
  ddr3_rw_arbiter_if.master                    app,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [USER_ADDR_WIDTH-1:0]           wr_addr,
  input  logic [USER_DATA_WIDTH-1:0]           wr_data,
  input  logic                                 rd_valid,
  output logic                                 rd_ready,
  input  logic [USER_ADDR_WIDTH-1:0]           rd_addr,
  output logic                                 rsp_valid,
  output logic [USER_DATA_WIDTH-1:0]           rsp_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] rd_outstanding,
  output logic                                 rd_underflow
);
  localparam int RUN_WIDTH = $clog2(MAX_RUN + 1);
  localparam logic [RUN_WIDTH-1:0] RUN_MAX = RUN_WIDTH'(MAX_RUN);

  arb_state_t                state_q, state_n;
  arb_side_t                 last_q, last_n, grant_side;
  logic [RUN_WIDTH-1:0]      run_q, run_n;
  logic                      en_q, en_n, wren_q, wren_n;
  logic [2:0]                cmd_q, cmd_n;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_n;
  logic [APP_DATA_WIDTH-1:0] data_q, data_n;
  logic                      rd_avail, wr_elig, rd_elig, grant_valid, rd_accept;

  assign wr_elig   = wr_valid & init_calib_complete;
  assign rd_elig   = rd_valid & init_calib_complete & rd_avail;
  assign rd_accept = (state_q == RD_ISSUE) & en_q & app.app_rdy;

  ddr3_rd_credit #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_rd_credit (
    .clk           (clk),
    .rst           (rst),
    .rd_accept     (rd_accept),
    .rd_beat       (app.app_rd_data_valid),
    .rd_outstanding(rd_outstanding),
    .rd_avail      (rd_avail),
    .rd_underflow  (rd_underflow)
  );

  // run_q==0 only before the first grant; last_q resets to READ so that tie goes to write.
  always_comb begin
    grant_valid = 1'b0;
    grant_side  = last_q;
    if (wr_elig && rd_elig) begin
      grant_valid = 1'b1;
      if (run_q == '0)          grant_side = SIDE_WRITE;
      else if (run_q < RUN_MAX) grant_side = last_q;
      else                      grant_side = other_side(last_q);
    end else if (wr_elig) begin
      grant_valid = 1'b1;
      grant_side  = SIDE_WRITE;
    end else if (rd_elig) begin
      grant_valid = 1'b1;
      grant_side  = SIDE_READ;
    end
  end

  always_comb begin
    state_n  = state_q;
    last_n   = last_q;
    run_n    = run_q;
    en_n     = en_q;
    cmd_n    = cmd_q;
    addr_n   = addr_q;
    wren_n   = wren_q;
    data_n   = data_q;
    wr_ready = 1'b0;
    rd_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          en_n = 1'b1;
          if (grant_side == SIDE_WRITE) begin
            wr_ready = 1'b1;
            state_n  = WR_ISSUE;
            cmd_n    = CMD_WRITE;
            addr_n   = ADDR_WIDTH'(wr_addr);
            wren_n   = 1'b1;
            data_n   = APP_DATA_WIDTH'(wr_data);
          end else begin
            rd_ready = 1'b1;
            state_n  = RD_ISSUE;
            cmd_n    = CMD_READ;
            addr_n   = ADDR_WIDTH'(rd_addr);
          end
          if (grant_side == last_q) begin
            run_n = (run_q < RUN_MAX) ? run_q + RUN_WIDTH'(1) : RUN_MAX;
          end else begin
            run_n  = RUN_WIDTH'(1);
            last_n = grant_side;
          end
        end
      end
      // Command and write-data strobes retire independently; leave once both are gone.
      WR_ISSUE: begin
        if (en_q && app.app_rdy) begin
          en_n   = 1'b0;
          cmd_n  = CMD_WRITE;
          addr_n = '0;
        end
        if (wren_q && app.app_wdf_rdy) begin
          wren_n = 1'b0;
          data_n = '0;
        end
        if (!en_n && !wren_n) state_n = IDLE;
      end
      RD_ISSUE: begin
        if (app.app_rdy) begin
          en_n    = 1'b0;
          cmd_n   = CMD_WRITE;
          addr_n  = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= SIDE_READ;
      run_q     <= '0;
      en_q      <= 1'b0;
      cmd_q     <= CMD_WRITE;
      addr_q    <= '0;
      wren_q    <= 1'b0;
      data_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state_q   <= state_n;
      last_q    <= last_n;
      run_q     <= run_n;
      en_q      <= en_n;
      cmd_q     <= cmd_n;
      addr_q    <= addr_n;
      wren_q    <= wren_n;
      data_q    <= data_n;
      rsp_valid <= app.app_rd_data_valid;
      rsp_data  <= USER_DATA_WIDTH'(app.app_rd_data);
    end
  end

  assign app.app_en       = en_q;
  assign app.app_cmd      = cmd_q;
  assign app.app_addr     = addr_q;
  assign app.app_wdf_data = data_q;
  assign app.app_wdf_wren = wren_q;
  assign app.app_wdf_end  = wren_q;
  assign app.app_wdf_mask = '0;
  assign app.app_burst    = 1'b0;
endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// Bench for ddr3_rw_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_ddr3_rw_arbiter;
  localparam int MAXR = 2;
  localparam int MAXO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        calib = 1'b0;
  logic        wr_valid = 1'b0, rd_valid = 1'b0;
  logic        wr_ready, rd_ready, rsp_valid, rd_underflow;
  logic [15:0] wr_addr = '0, rd_addr = '0;
  logic [47:0] wr_data = '0, rsp_data;
  logic [3:0]  rd_outstanding;

  always #5 clk = ~clk;

  ddr3_rw_arbiter_if #(.ADDR_WIDTH(28), .APP_DATA_WIDTH(64), .APP_MASK_WIDTH(8)) app_bus ();

  ddr3_rw_arbiter #(
    .ADDR_WIDTH(28), .APP_DATA_WIDTH(64), .APP_MASK_WIDTH(8),
    .USER_ADDR_WIDTH(16), .USER_DATA_WIDTH(48),
    .MAX_RUN(MAXR), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .init_calib_complete(calib), .app(app_bus),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rd_outstanding(rd_outstanding), .rd_underflow(rd_underflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: what is pending at the controller, grant history, read credits, response pipe.
  bit          m_en, m_wren, m_isrd, m_last_rd, m_unf, m_rspv;
  int          m_run, m_out;
  logic [27:0] m_addr;
  logic [63:0] m_data;
  logic [47:0] m_rspd;
  bit          e_wr, e_rd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_wren = 0; m_isrd = 0; m_last_rd = 1; m_unf = 0; m_rspv = 0;
    m_run = 0; m_out = 0; m_addr = '0; m_data = '0; m_rspd = '0;
  endtask

  task automatic predict();
    bit idle, we, re;
    idle = !m_en && !m_wren;
    we = idle && wr_valid && calib;
    re = idle && rd_valid && calib && (m_out < MAXO);
    e_wr = 0; e_rd = 0;
    if (we && re) begin
      if (m_run == 0)         e_wr = 1;
      else if (m_run < MAXR)  begin e_rd = m_last_rd;  e_wr = !m_last_rd; end
      else                    begin e_rd = !m_last_rd; e_wr = m_last_rd;  end
    end else begin
      e_wr = we; e_rd = re;
    end
  endtask

  task automatic check_outputs();
    predict();
    check("wr_ready",       64'(wr_ready),                 64'(e_wr));
    check("rd_ready",       64'(rd_ready),                 64'(e_rd));
    check("app_en",         64'(app_bus.app_en),           64'(m_en));
    check("app_cmd",        64'(app_bus.app_cmd),          (m_en && m_isrd) ? 64'd1 : 64'd0);
    check("app_addr",       64'(app_bus.app_addr),         m_en ? 64'(m_addr) : 64'd0);
    check("app_wdf_wren",   64'(app_bus.app_wdf_wren),     64'(m_wren));
    check("app_wdf_end",    64'(app_bus.app_wdf_end),      64'(m_wren));
    check("app_wdf_data",   app_bus.app_wdf_data,          m_wren ? m_data : 64'd0);
    check("app_wdf_mask",   64'(app_bus.app_wdf_mask),     64'd0);
    check("app_burst",      64'(app_bus.app_burst),        64'd0);
    check("rd_outstanding", 64'(rd_outstanding),           64'(m_out));
    check("rd_underflow",   64'(rd_underflow),             64'(m_unf));
    check("rsp_valid",      64'(rsp_valid),                64'(m_rspv));
    check("rsp_data",       64'(rsp_data),                 64'(m_rspd));
  endtask

  task automatic model_update();
    bit acc_rd;
    acc_rd = m_en && m_isrd && app_bus.app_rdy;
    if (e_wr || e_rd) begin
      m_en   = 1;
      m_isrd = e_rd;
      m_wren = e_wr;
      m_addr = {12'h0, (e_rd ? rd_addr : wr_addr)};
      m_data = e_wr ? {16'h0, wr_data} : 64'd0;
      if (m_run > 0 && e_rd == m_last_rd) m_run = (m_run < MAXR) ? m_run + 1 : MAXR;
      else m_run = 1;
      m_last_rd = e_rd;
    end else begin
      if (m_en && app_bus.app_rdy)       m_en = 0;
      if (m_wren && app_bus.app_wdf_rdy) m_wren = 0;
    end
    if (acc_rd && !app_bus.app_rd_data_valid) m_out++;
    else if (!acc_rd && app_bus.app_rd_data_valid) begin
      if (m_out == 0) m_unf = 1;
      else            m_out--;
    end
    m_rspv = app_bus.app_rd_data_valid;
    m_rspd = app_bus.app_rd_data[47:0];
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    model_update();
    @(negedge clk);
  endtask

  initial begin
    logic [5:0]  seq;
    logic [63:0] t2_data;
    int          ngrant, en_cnt, wren_cnt, wr_cnt;

    app_bus.app_rdy = 0; app_bus.app_wdf_rdy = 0;
    app_bus.app_rd_data_valid = 0; app_bus.app_rd_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_outputs();
    rst = 0;
    @(negedge clk);

    // Calibration gate, then the first tie goes to write.
    wr_valid = 1; rd_valid = 1; wr_addr = 16'h0100; rd_addr = 16'h0200; wr_data = 48'h1;
    app_bus.app_rdy = 1; app_bus.app_wdf_rdy = 1;
    repeat (3) cycle();
    calib = 1;
    #1 check("t1_first_grant_wr", 64'(wr_ready), 64'd1);
    cycle();
    wr_valid = 0; rd_valid = 0;
    cycle();

    // Write data held while app_wdf_rdy is low.
    wr_valid = 1; wr_addr = 16'h0012; wr_data = 48'hA5A5_0000_1234;
    app_bus.app_rdy = 1; app_bus.app_wdf_rdy = 0;
    cycle();
    wr_valid = 0; en_cnt = 0; wren_cnt = 0; t2_data = '0;
    for (int i = 0; i < 5; i++) begin
      app_bus.app_wdf_rdy = (i >= 3);
      #1;
      if (app_bus.app_en) en_cnt++;
      if (app_bus.app_wdf_wren) wren_cnt++;
      if (i == 0) t2_data = app_bus.app_wdf_data;
      cycle();
    end
    check("t2_en_cycles", 64'(en_cnt), 64'd1);
    check("t2_wren_cycles", 64'(wren_cnt), 64'd4);
    check("t2_wdf_data", t2_data, 64'h0000_A5A5_0000_1234);

    // Both requesting: bounded runs of MAX_RUN.
    wr_valid = 1; rd_valid = 1; app_bus.app_wdf_rdy = 1;
    seq = '0; ngrant = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (wr_ready || rd_ready) begin seq = {seq[4:0], rd_ready}; ngrant++; end
      cycle();
    end
    check("t3_grant_count", 64'(ngrant), 64'd6);
    check("t3_grant_pattern", 64'(seq), 64'b110011);
    rd_valid = 0; wr_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (wr_ready) wr_cnt++;
      cycle();
    end
    check("t3_wr_only_rate", 64'(wr_cnt), 64'd4);

    // Outstanding-read cap and release.
    wr_valid = 0; rd_valid = 1;
    repeat (20) cycle();
    check("t4_cap_count", 64'(rd_outstanding), 64'd8);
    check("t4_cap_ready", 64'(rd_ready), 64'd0);
    app_bus.app_rd_data_valid = 1; app_bus.app_rd_data = 64'h1111_2222_3333_4444;
    cycle();
    app_bus.app_rd_data_valid = 0;
    check("t4_after_beat", 64'(rd_outstanding), 64'd7);
    check("t4_regrant", 64'(rd_ready), 64'd1);
    cycle();

    // Accept and beat in the same cycle.
    rd_valid = 0;
    app_bus.app_rd_data_valid = 1; app_bus.app_rd_data = 64'hDEAD_BEEF_CAFE_1234;
    cycle();
    app_bus.app_rd_data_valid = 0;
    check("t5_count_same", 64'(rd_outstanding), 64'd7);
    check("t5_rsp_valid", 64'(rsp_valid), 64'd1);
    check("t5_rsp_data", 64'(rsp_data), 64'h0000_BEEF_CAFE_1234);

    // Drain, then a beat at zero sets the sticky underflow.
    app_bus.app_rd_data_valid = 1;
    repeat (7) cycle();
    app_bus.app_rd_data_valid = 0;
    check("t6_drained", 64'(rd_outstanding), 64'd0);
    check("t6_no_unf", 64'(rd_underflow), 64'd0);
    app_bus.app_rd_data_valid = 1;
    cycle();
    app_bus.app_rd_data_valid = 0;
    check("t6_unf", 64'(rd_underflow), 64'd1);
    check("t6_count_zero", 64'(rd_outstanding), 64'd0);

    // Asynchronous reset while a write is pending.
    wr_valid = 1; wr_addr = 16'h0BEE; wr_data = 48'h1234_5678_9ABC;
    app_bus.app_rdy = 0; app_bus.app_wdf_rdy = 0;
    cycle();
    wr_valid = 0;
    cycle();
    #1 check("t7_pre_en", 64'(app_bus.app_en), 64'd1);
    #2 rst = 1;
    #1;
    model_reset();
    check_outputs();
    check("t7_async_en", 64'(app_bus.app_en), 64'd0);
    check("t7_async_unf", 64'(rd_underflow), 64'd0);
    @(negedge clk);
    rst = 0;

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      calib    = ($urandom_range(0, 9) != 0);
      wr_valid = ($urandom_range(0, 2) != 0);
      rd_valid = ($urandom_range(0, 1) != 0);
      wr_addr  = 16'($urandom);
      rd_addr  = 16'($urandom);
      wr_data  = 48'({$urandom, $urandom});
      app_bus.app_rdy     = ($urandom_range(0, 2) != 0);
      app_bus.app_wdf_rdy = ($urandom_range(0, 2) != 0);
      app_bus.app_rd_data = {$urandom, $urandom};
      app_bus.app_rd_data_valid = (m_out > 0) ? ($urandom_range(0, 4) < 2)
                                              : ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
